// File: rtl/string_arb_pkg.sv
// Shared types and default sizing for the string stream arbiter.
package string_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_STREAM, ARB_FLUSH} arb_state_t;

  localparam int DEF_N_REQ   = 3;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_MAX_LEN = 64;
  localparam int STAT_W      = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import string_arb_pkg::*;
#(
  parameter int N   = DEF_N_REQ,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < int'(N); k++) begin
      j = (int'(ptr) + k) % int'(N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/string_stream_arbiter.sv
// Round-robin arbiter granting whole byte strings from N_REQ sources to one engine.
// Optional per-source completed-string counters: define STR_ARB_STATS_EN.
module string_stream_arbiter
  import string_arb_pkg::*;
#(
  parameter  int N_REQ   = DEF_N_REQ,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     eng_valid,
  output logic [DATA_W-1:0]        eng_data,
  output logic                     eng_last,
  output logic [ID_W-1:0]          eng_src,
  input  logic                     eng_ready,
  output logic                     busy,
  output logic                     err_overlen
`ifdef STR_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]  str_count
`endif
);

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   next_ptr;
  logic [LEN_W-1:0]  cnt;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              at_max;
  logic              hs;
  logic              str_done;

  rr_picker #(.N(N_REQ), .IDW(ID_W)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign sel_valid = req_valid[grant];
  assign sel_data  = req_data[grant*DATA_W +: DATA_W];
  assign sel_last  = req_last[grant];
  assign at_max    = (cnt == LEN_W'(MAX_LEN - 1));
  assign next_ptr  = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
  assign eng_src   = grant;
  assign busy      = (state != ARB_IDLE);
  // A string completes on its last byte or when it is cut at MAX_LEN.
  assign str_done  = (state == ARB_STREAM) && hs && (sel_last || at_max);

  // Next-state and pass-through of the granted source.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    eng_valid = 1'b0;
    eng_data  = '0;
    eng_last  = 1'b0;
    hs        = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) state_nxt = ARB_STREAM;
      end
      ARB_STREAM: begin
        eng_valid        = sel_valid;
        eng_data         = sel_data;
        eng_last         = sel_last || at_max;
        req_ready[grant] = eng_ready;
        hs               = sel_valid && eng_ready;
        if (hs) begin
          if (sel_last)    state_nxt = ARB_IDLE;
          else if (at_max) state_nxt = ARB_FLUSH;
        end
      end
      ARB_FLUSH: begin
        req_ready[grant] = 1'b1;
        if (sel_valid && sel_last) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // State, grant, pointer, length counter and truncation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      err_overlen <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_overlen <= 1'b0;
      case (state)
        ARB_IDLE: begin
          cnt <= '0;
          if (pick_found) grant <= pick_idx;
        end
        ARB_STREAM: begin
          if (hs) begin
            if (sel_last) begin
              cnt    <= '0;
              rr_ptr <= next_ptr;
            end else if (at_max) begin
              cnt         <= '0;
              rr_ptr      <= next_ptr;
              err_overlen <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STR_ARB_STATS_EN
  // Saturating per-source count of completed (including truncated) strings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      str_count <= '0;
    end else if (str_done && (str_count[grant*STAT_W +: STAT_W] != '1)) begin
      str_count[grant*STAT_W +: STAT_W] <= str_count[grant*STAT_W +: STAT_W] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_string_stream_arbiter.sv
// Self-checking bench for string_stream_arbiter.
module tb_string_stream_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int ML = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          eng_valid;
  logic [DW-1:0] eng_data;
  logic          eng_last;
  logic [1:0]    eng_src;
  logic          eng_ready = 1'b0;
  logic          busy;
  logic          err_overlen;
`ifdef STR_ARB_STATS_EN
  logic [N*16-1:0] str_count;
`endif

  always #5 clk = ~clk;

  string_stream_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .eng_valid(eng_valid), .eng_data(eng_data), .eng_last(eng_last), .eng_src(eng_src),
    .eng_ready(eng_ready), .busy(busy), .err_overlen(err_overlen)
`ifdef STR_ARB_STATS_EN
    , .str_count(str_count)
`endif
  );

  // Source byte queues ({last, byte}), expected and observed delivery logs.
  logic [8:0] sq      [N][$];
  logic [8:0] exp_log [N][$];
  logic [8:0] got_log [N][$];
  int         src_log [$];
  bit         rand_src = 0;
  int         rdy_mode = 0;   // 0: ready high, 1: random, 2: held low
  int         n_pass = 0, n_total = 0, n_fail = 0, err_seen = 0;

  // Reference: who owns the engine, whether the rest of a string is dropped.
  int m_owner = -1, m_cnt = 0, m_ptr = 0, m_src = 0;
  bit m_discard = 0, m_err = 0;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  task automatic send_str(input int s, input int len, input int first, input bit rnd);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = rnd ? 8'($urandom) : 8'(first + k);
      sq[s].push_back({(k == len - 1), b});
      if (k < ML) exp_log[s].push_back({(k == len - 1) || (k == ML - 1), b});
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_src = 0; m_discard = 0; m_err = 0;
  endtask

  task automatic drive();
    bit on;
    for (int s = 0; s < N; s++) begin
      on = rand_src ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sq[s].size() > 0 && on) begin
        req_valid[s] = 1'b1;
        req_data[s*DW +: DW] = sq[s][0][7:0];
        req_last[s] = sq[s][0][8];
      end else begin
        req_valid[s] = 1'b0;
        req_data[s*DW +: DW] = 8'($urandom);
        req_last[s] = 1'($urandom_range(0, 1));
      end
    end
    case (rdy_mode)
      0:       eng_ready = 1'b1;
      1:       eng_ready = 1'($urandom_range(0, 1));
      default: eng_ready = 1'b0;
    endcase
  endtask

  // Apply the rules at a clock edge, using the inputs that were presented.
  task automatic model_step();
    logic [8:0] head;
    bit found;
    int i;
    m_err = 0;
    found = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!found && req_valid[i]) begin
          found = 1; m_owner = i; m_src = i; m_cnt = 0;
        end
      end
    end else if (m_discard) begin
      if (req_valid[m_owner]) begin
        head = sq[m_owner].pop_front();
        if (head[8]) begin m_owner = -1; m_discard = 0; end
      end
    end else if (req_valid[m_owner] && eng_ready) begin
      head = sq[m_owner].pop_front();
      if (head[8]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
      end else if (m_cnt == ML - 1) begin
        m_ptr = (m_owner + 1) % N; m_discard = 1; m_err = 1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, advance the reference at posedge.
  task automatic cycle();
    logic [N-1:0] x_rdy;
    logic x_valid, x_last;
    logic [7:0] x_data;
    logic [8:0] head;
    drive();
    #1;
    x_rdy = '0; x_valid = 0; x_data = '0; x_last = 0;
    if (m_owner >= 0) begin
      if (m_discard) x_rdy[m_owner] = 1'b1;
      else begin
        x_rdy[m_owner] = eng_ready;
        x_valid = req_valid[m_owner];
        if (x_valid) begin
          head = sq[m_owner][0];
          x_data = head[7:0];
          x_last = head[8] || (m_cnt == ML - 1);
        end
      end
    end
    chk("busy", busy, (m_owner >= 0));
    chk("eng_valid", eng_valid, x_valid);
    chk("req_ready", req_ready, x_rdy);
    chk("eng_src", eng_src, m_src);
    chk("err_overlen", err_overlen, m_err);
    if (x_valid) begin
      chk("eng_data", eng_data, x_data);
      chk("eng_last", eng_last, x_last);
    end
    if (eng_valid === 1'b1 && eng_ready && eng_src < N) begin
      got_log[eng_src].push_back({eng_last, eng_data});
      if (eng_last) src_log.push_back(int'(eng_src));
    end
    if (err_overlen === 1'b1) err_seen++;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((m_owner >= 0 || sq[0].size() > 0 || sq[1].size() > 0 || sq[2].size() > 0) && c < maxc) begin
      cycle(); c++;
    end
    cycle(); cycle();
    chk("drain_in_budget", (c < maxc), 1);
  endtask

  task automatic compare_logs();
    for (int s = 0; s < N; s++) begin
      chk("log_len", got_log[s].size(), exp_log[s].size());
      for (int i = 0; i < exp_log[s].size() && i < got_log[s].size(); i++)
        chk("log_byte", got_log[s][i], exp_log[s][i]);
      got_log[s].delete(); exp_log[s].delete(); sq[s].delete();
    end
  endtask

  task automatic check_order(input int a, input int b, input int c);
    int e[3];
    e[0] = a; e[1] = b; e[2] = c;
    chk("order_len", src_log.size(), 3);
    for (int i = 0; i < 3 && i < src_log.size(); i++) chk("order_src", src_log[i], e[i]);
  endtask

  initial begin
    int c;
    logic [7:0] d_stall;
    int fair_exp[6];
    fair_exp = '{0, 1, 2, 0, 1, 2};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_eng_valid", eng_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_eng_src", eng_src, 0);
    chk("rst_eng_last", eng_last, 0);
    chk("rst_err", err_overlen, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: every source offers two 2-byte strings
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) send_str(s, 2, 16 * s + 2 * r, 0);
    src_log.delete();
    drain(200);
    chk("fair_count", src_log.size(), 6);
    for (int i = 0; i < 6 && i < src_log.size(); i++) chk("fair_src", src_log[i], fair_exp[i]);
    compare_logs();

    // Single string "abc" on source 0
    send_str(0, 3, 8'h61, 0);
    drain(50);
    compare_logs();

    // Backpressure on source 1: stall five cycles after two bytes
    send_str(1, 6, 8'h30, 0);
    c = 0;
    while (got_log[1].size() < 2 && c < 50) begin cycle(); c++; end
    chk("bp_reach", (c < 50), 1);
    d_stall = sq[1][0][7:0];
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_valid", eng_valid, 1);
      chk("stall_data", eng_data, d_stall);
      chk("stall_ready", req_ready[1], 0);
    end
    rdy_mode = 0;
    drain(50);
    compare_logs();

    // Overlength string on source 2, others queue up behind it
    err_seen = 0;
    src_log.delete();
    send_str(2, 70, 0, 1);
    cycle(); cycle(); cycle();
    send_str(0, 3, 0, 1);
    send_str(1, 3, 0, 1);
    drain(300);
    chk("ovl_err_pulses", err_seen, 1);
    check_order(2, 0, 1);
    compare_logs();

    // Exactly MAX_LEN bytes: normal end, no truncation
    err_seen = 0;
    send_str(0, ML, 0, 1);
    drain(200);
    chk("exact_err_pulses", err_seen, 0);
    compare_logs();

    // Random traffic, gaps on sources and engine
    rand_src = 1; rdy_mode = 1;
    for (int r = 0; r < 4; r++)
      for (int s = 0; s < N; s++) send_str(s, $urandom_range(1, 80), 0, 1);
    drain(20000);
    compare_logs();
    rand_src = 0; rdy_mode = 0;

    // Reset during byte 3 of a 10-byte string
    send_str(1, 10, 0, 1);
    c = 0;
    while (got_log[1].size() < 2 && c < 50) begin cycle(); c++; end
    chk("rst_reach", (c < 50), 1);
    drive();
    #2;
    chk("pre_rst_valid", eng_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_eng_valid", eng_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_eng_src", eng_src, 0);
    chk("arst_eng_last", eng_last, 0);
    chk("arst_err", err_overlen, 0);
    @(posedge clk); @(negedge clk);
    for (int s = 0; s < N; s++) begin sq[s].delete(); got_log[s].delete(); exp_log[s].delete(); end
    model_reset();
    rst_n = 1'b1;
    src_log.delete();
    send_str(1, 2, 0, 1);
    send_str(2, 2, 0, 1);
    send_str(0, 2, 0, 1);
    drain(100);
    check_order(0, 1, 2);
    compare_logs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/string_stream_arbiter.md
Name: string_stream_arbiter

Overview:
- Shares one string-processing engine among N_REQ byte-stream sources, e.g. the small-, medium- and large-string traffic paths.
- Grants whole strings, from first byte to `last`, round-robin; a string is never interleaved with another.
- Tags the engine side with the source id and enforces a maximum string length.
- Sits between the per-source stream interfaces and the engine input port.

Parameters:
- N_REQ, 3, number of requesters.
- DATA_W, 8, character width in bits.
- MAX_LEN, 64, maximum bytes per string (≥2).
- LEN_W, $clog2(MAX_LEN+1), length counter width (derived, localparam).
- ID_W, $clog2(N_REQ), source id width (derived, localparam; minimum 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  N_REQ  per-source byte valid.
- req_data  in  N_REQ*DATA_W  per-source byte; source i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  final byte of the string.
- req_ready  out  N_REQ  per-source accept.
- eng_valid  out  1  byte valid to engine.
- eng_data  out  DATA_W  byte to engine.
- eng_last  out  1  final byte to engine.
- eng_src  out  ID_W  id of the granted source; stable for the whole string.
- eng_ready  in  1  engine accept.
- busy  out  1  high in any state other than IDLE.
- err_overlen  out  1  one-cycle pulse when a string is truncated.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, rr_ptr=0, cnt=0.
  - All outputs 0: req_ready, eng_valid, eng_last, eng_src, busy, err_overlen.
- A handshake occurs on a channel when valid && ready are both high at a rising clk edge.
- FSM states: IDLE, STREAM, FLUSH.
- IDLE:
  - Select the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - Register grant=i; eng_src=i; go to STREAM the next cycle.
  - No byte is transferred in the arbitration cycle, so there is a 1-cycle bubble per string.
- STREAM, combinational pass-through of the granted source:
  - eng_valid = req_valid[grant]
  - eng_data = req_data[grant]
  - eng_last = req_last[grant] || (cnt == MAX_LEN-1)
  - req_ready[grant] = eng_ready; all other req_ready bits are 0.
- On each engine handshake, cnt increments.
- If the handshaked byte has req_last=1:
  - Go to IDLE; rr_ptr = (grant+1) mod N_REQ; cnt=0.
- If it is the MAX_LEN-th byte and req_last=0:
  - Byte is sent with eng_last=1; err_overlen pulses on the next cycle.
  - Go to FLUSH; rr_ptr advances; cnt=0.
- A byte that hits MAX_LEN and also carries req_last=1 is a normal end: no error, go to IDLE.
- FLUSH:
  - req_ready[grant]=1 and eng_valid=0.
  - Discard source bytes until a handshake with req_last=1, then go to IDLE.
- Input valid rules:
  - A source may drop req_valid mid-string. The grant is held, and eng_valid follows the source.
  - Valid on non-granted sources is ignored.
- Fairness: with all sources requesting continuously, the grant order is 0,1,2,0,… One string per grant.
- An asynchronous reset mid-string aborts the transfer immediately; the engine sees eng_valid fall to 0.
- eng_ready toggling while eng_valid=0 has no effect.

Optional Feature:
- Macro: STR_ARB_STATS_EN.
- When defined:
  - Adds output port str_count, N_REQ*16 bits.
  - One 16-bit per-source counter of completed strings, incremented on each IDLE-bound (normal) completion.
  - Truncated strings are also counted.
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined: the port and the counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package string_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_STREAM, ARB_FLUSH} arb_state_t
  - default DATA_W and MAX_LEN constants
- Sub-module rr_picker, combinational:
  - Inputs: req vector and pointer.
  - Outputs: found flag and index.
  - Instantiated once.

Test Plan:
- Single string: source 0 sends "abc" (3 bytes, last on 'c'), eng_ready=1. Expect:
  - eng_data 'a','b','c' on consecutive cycles after the 1-cycle arbitration bubble
  - eng_src=0 and eng_last only on 'c'
  - busy falls the cycle after the last handshake
- Fairness: all 3 sources continuously offer 2-byte strings. Expect eng_src sequence 0,1,2,0,1,2 with no interleaving inside a string.
- Backpressure: eng_ready held low for 5 cycles mid-string on source 1. Expect:
  - eng_data and eng_valid stable across the stall
  - req_ready[1]=0 during the stall
  - no byte lost or duplicated
- Overlength (MAX_LEN=64): source 2 sends a 70-byte string. Expect:
  - 64 bytes forwarded, the 64th with eng_last=1
  - err_overlen=1 for 1 cycle
  - 6 bytes absorbed in FLUSH with eng_valid=0
  - next grant goes to source 0
- Exact length: a 64-byte string with last on byte 64. Expect eng_last on byte 64 and err_overlen stays 0.
- Reset mid-string: rst_n pulsed low during byte 3 of 10. Expect:
  - all outputs 0 asynchronously
  - after release, arbitration restarts from source 0
